// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester ports (IF/LD/ST) and the single memory
// command/return port that the arbiter sits between.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic [DATA_W-1:0] if_rdata;
   logic              if_rvalid;

   logic              ld_req;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_gnt;
   logic [DATA_W-1:0] ld_rdata;
   logic              ld_rvalid;

   logic              st_req;
   logic [ADDR_W-1:0] st_addr;
   logic [DATA_W-1:0] st_wdata;
   logic              st_gnt;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              fetch_stall;

   // Arbiter side.
   modport slave (
      input  if_req, if_addr, ld_req, ld_addr, st_req, st_addr, st_wdata, mem_rdata,
      output if_gnt, if_rdata, if_rvalid, ld_gnt, ld_rdata, ld_rvalid, st_gnt,
             mem_en, mem_we, mem_addr, mem_wdata, fetch_stall
   );

   // Requester / memory side.
   modport master (
      output if_req, if_addr, ld_req, ld_addr, st_req, st_addr, st_wdata, mem_rdata,
      input  if_gnt, if_rdata, if_rvalid, ld_gnt, ld_rdata, ld_rvalid, st_gnt,
             mem_en, mem_we, mem_addr, mem_wdata, fetch_stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the CPU: store > load > fetch priority with
// fetch promotion after STARVE_MAX denied cycles, registered memory command,
// and tagged routing of read data back to the issuing requester.
module mem_port_arbiter #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              resetn,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_IF   = 2'd1,
      TAG_LD   = 2'd2
   } tag_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0]        starve_cnt;
   logic              promote;
   logic              st_win;
   logic              ld_win;
   logic              if_win;
   logic              any_win;

   logic              cmd_en_p0;
   logic              cmd_we_p0;
   logic [ADDR_W-1:0] cmd_addr_p0;
   logic [DATA_W-1:0] cmd_wdata_p0;

   // tag_p[k] describes the access issued k+1 cycles ago; the last entry
   // lines up with mem_rdata for that access.
   tag_t              tag_p [RD_LAT+1];
   logic              if_vld;
   logic              ld_vld;
   logic [DATA_W-1:0] if_hold;
   logic [DATA_W-1:0] ld_hold;

   function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
      sat_inc = (cnt >= STARVE_LIM) ? STARVE_LIM : cnt + 4'd1;
   endfunction

   assign promote = bus.if_req && (starve_cnt == STARVE_LIM);

   // Grant selection: promoted fetch first, otherwise fixed ST > LD > IF.
   always_comb begin
      st_win = 1'b0;
      ld_win = 1'b0;
      if_win = 1'b0;
      if (!resetn) begin
         if (promote)          if_win = 1'b1;
         else if (bus.st_req)  st_win = 1'b1;
         else if (bus.ld_req)  ld_win = 1'b1;
         else if (bus.if_req)  if_win = 1'b1;
      end
   end

   assign any_win         = st_win | ld_win | if_win;
   assign bus.st_gnt      = st_win;
   assign bus.ld_gnt      = ld_win;
   assign bus.if_gnt      = if_win;
   assign bus.fetch_stall = bus.if_req & ~if_win;

   // Fetch starvation counter: counts consecutive denied fetch cycles.
   always_ff @(posedge clk) begin
      if (resetn)                          starve_cnt <= 4'd0;
      else if (if_win || !bus.if_req)      starve_cnt <= 4'd0;
      else                                 starve_cnt <= sat_inc(starve_cnt);
   end

   // Stage p0: registered memory command; address/data hold when idle.
   always_ff @(posedge clk) begin
      if (resetn) begin
         cmd_en_p0    <= 1'b0;
         cmd_we_p0    <= 1'b0;
         cmd_addr_p0  <= '0;
         cmd_wdata_p0 <= '0;
      end else begin
         cmd_en_p0 <= any_win;
         cmd_we_p0 <= st_win;
         if (st_win) begin
            cmd_addr_p0  <= bus.st_addr;
            cmd_wdata_p0 <= bus.st_wdata;
         end else if (ld_win) begin
            cmd_addr_p0  <= bus.ld_addr;
         end else if (if_win) begin
            cmd_addr_p0  <= bus.if_addr;
         end
      end
   end

   assign bus.mem_en    = cmd_en_p0;
   assign bus.mem_we    = cmd_we_p0;
   assign bus.mem_addr  = cmd_addr_p0;
   assign bus.mem_wdata = cmd_wdata_p0;

   // Read tag pipeline; reset flushes it so in-flight reads never return.
   always_ff @(posedge clk) begin
      if (resetn) begin
         for (int k = 0; k <= RD_LAT; k++) tag_p[k] <= TAG_NONE;
      end else begin
         tag_p[0] <= if_win ? TAG_IF : (ld_win ? TAG_LD : TAG_NONE);
         for (int k = 1; k <= RD_LAT; k++) tag_p[k] <= tag_p[k-1];
      end
   end

   assign if_vld = !resetn && (tag_p[RD_LAT] == TAG_IF);
   assign ld_vld = !resetn && (tag_p[RD_LAT] == TAG_LD);

   // Return data hold registers: keep the last delivered word per requester.
   always_ff @(posedge clk) begin
      if (resetn) begin
         if_hold <= '0;
         ld_hold <= '0;
      end else begin
         if (if_vld) if_hold <= bus.mem_rdata;
         if (ld_vld) ld_hold <= bus.mem_rdata;
      end
   end

   assign bus.if_rvalid = if_vld;
   assign bus.ld_rvalid = ld_vld;
   assign bus.if_rdata  = resetn ? '0 : (if_vld ? bus.mem_rdata : if_hold);
   assign bus.ld_rdata  = resetn ? '0 : (ld_vld ? bus.mem_rdata : ld_hold);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all checked each cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
   localparam int ADDR_W     = 11;
   localparam int DATA_W     = 32;
   localparam int RD_LAT     = 1;
   localparam int STARVE_MAX = 4;
   localparam int DEPTH      = 1 << ADDR_W;

   logic clk = 1'b0;
   logic resetn;
   logic init_mem;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus)
   );

   // Memory: write on the command edge, read data after RD_LAT edges.
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_pipe [RD_LAT];

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEAD0000 | 32'(i);
      end else if (bus.mem_en && bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
      rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 32'hBADBAD00;
      for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end

   assign bus.mem_rdata = rd_pipe[RD_LAT-1];

   typedef struct {
      int                due;
      bit                is_ld;
      logic [DATA_W-1:0] data;
   } ret_t;

   int                total = 0;
   int                bad   = 0;
   int                cyc   = 0;
   int                starve;
   ret_t              pend [$];
   logic [DATA_W-1:0] shadow [DEPTH];
   logic [DATA_W-1:0] hold_if, hold_ld;
   logic              e_en, e_we;
   logic [ADDR_W-1:0] e_addr;
   logic [DATA_W-1:0] e_wdata;
   logic              obs_if_gnt, obs_ld_rvalid, obs_if_rvalid;

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: check DUT against the model, then advance the model.
   task automatic do_cycle();
      bit   g_st, g_ld, g_if, v_if, v_ld;
      ret_t r;
      @(negedge clk);
      g_st = 0; g_ld = 0; g_if = 0; v_if = 0; v_ld = 0;
      if (!resetn) begin
         if (bus.if_req && starve == STARVE_MAX) g_if = 1;
         else if (bus.st_req)                    g_st = 1;
         else if (bus.ld_req)                    g_ld = 1;
         else if (bus.if_req)                    g_if = 1;
      end
      if (resetn) begin
         pend.delete();
         hold_if = '0;
         hold_ld = '0;
      end else if (pend.size() > 0 && pend[0].due == cyc) begin
         r = pend.pop_front();
         if (r.is_ld) begin v_ld = 1; hold_ld = r.data; end
         else         begin v_if = 1; hold_if = r.data; end
      end

      obs_if_gnt    = bus.if_gnt;
      obs_ld_rvalid = bus.ld_rvalid;
      obs_if_rvalid = bus.if_rvalid;

      chk("st_gnt",      32'(bus.st_gnt),      32'(g_st));
      chk("ld_gnt",      32'(bus.ld_gnt),      32'(g_ld));
      chk("if_gnt",      32'(bus.if_gnt),      32'(g_if));
      chk("fetch_stall", 32'(bus.fetch_stall), 32'(bus.if_req & ~g_if));
      chk("if_rvalid",   32'(bus.if_rvalid),   32'(v_if));
      chk("ld_rvalid",   32'(bus.ld_rvalid),   32'(v_ld));
      chk("if_rdata",    bus.if_rdata,         hold_if);
      chk("ld_rdata",    bus.ld_rdata,         hold_ld);
      chk("mem_en",      32'(bus.mem_en),      32'(e_en));
      chk("mem_we",      32'(bus.mem_we),      32'(e_we));
      chk("mem_addr",    32'(bus.mem_addr),    32'(e_addr));
      chk("mem_wdata",   bus.mem_wdata,        e_wdata);

      if (resetn) begin
         starve = 0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      end else begin
         if (g_if || !bus.if_req)     starve = 0;
         else if (starve < STARVE_MAX) starve++;
         e_en = g_st | g_ld | g_if;
         e_we = g_st;
         if (g_st) begin
            e_addr = bus.st_addr;
            e_wdata = bus.st_wdata;
            shadow[bus.st_addr] = bus.st_wdata;
         end else if (g_ld) begin
            e_addr = bus.ld_addr;
            pend.push_back(ret_t'{cyc + 1 + RD_LAT, 1'b1, shadow[bus.ld_addr]});
         end else if (g_if) begin
            e_addr = bus.if_addr;
            pend.push_back(ret_t'{cyc + 1 + RD_LAT, 1'b0, shadow[bus.if_addr]});
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle();
      bus.if_req = 0; bus.ld_req = 0; bus.st_req = 0;
   endtask

   initial begin
      int first_gnt;
      int ld_seen;
      int if_seen;
      for (int i = 0; i < DEPTH; i++) shadow[i] = 32'hDEAD0000 | 32'(i);
      idle();
      bus.if_addr = '0; bus.ld_addr = '0; bus.st_addr = '0; bus.st_wdata = '0;
      resetn   = 1;
      init_mem = 1;
      @(posedge clk);
      #1;
      init_mem = 0;
      starve = 0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      hold_if = '0; hold_ld = '0;

      // Reset state: grants suppressed, fetch_stall follows if_req.
      bus.if_req = 1;
      do_cycle();
      do_cycle();
      resetn = 0;
      idle();
      do_cycle();

      // T1: single fetch from 0x005.
      bus.if_req = 1; bus.if_addr = 11'h005;
      do_cycle();
      idle();
      do_cycle();
      do_cycle();
      chk("t1_if_rdata", bus.if_rdata, 32'hDEAD0005);

      // T2: ST, LD, IF simultaneously; LD to the stored address sees new data.
      bus.st_req = 1; bus.ld_req = 1; bus.if_req = 1;
      bus.st_addr = 11'h010; bus.ld_addr = 11'h010; bus.st_wdata = 32'h12345678;
      bus.if_addr = 11'h020;
      do_cycle();
      bus.st_req = 0;
      do_cycle();
      bus.ld_req = 0;
      do_cycle();
      idle();
      repeat (3) do_cycle();
      chk("t2_ld_rdata", bus.ld_rdata, 32'h12345678);
      chk("t2_if_rdata", bus.if_rdata, 32'hDEAD0020);

      // T3: ST and LD saturating the port; IF promoted after STARVE_MAX denials.
      bus.st_req = 1; bus.ld_req = 1; bus.if_req = 1;
      bus.st_addr = 11'h100; bus.ld_addr = 11'h101; bus.if_addr = 11'h102;
      first_gnt = -1;
      for (int i = 0; i < 12; i++) begin
         bus.st_wdata = 32'hA0000000 | 32'(i);
         do_cycle();
         if (obs_if_gnt && first_gnt < 0) first_gnt = i;
      end
      chk("t3_if_gnt_cycle", 32'(first_gnt), 32'(STARVE_MAX));
      idle();
      repeat (3) do_cycle();

      // T4: alternating IF / LD reads, fully pipelined.
      if_seen = 0; ld_seen = 0;
      for (int i = 0; i < 8 + 1 + RD_LAT; i++) begin
         idle();
         if (i < 8) begin
            if (i % 2 == 0) begin bus.if_req = 1; bus.if_addr = ADDR_W'(32 + i); end
            else            begin bus.ld_req = 1; bus.ld_addr = ADDR_W'(64 + i); end
         end
         do_cycle();
         if_seen += int'(obs_if_rvalid);
         ld_seen += int'(obs_ld_rvalid);
      end
      chk("t4_if_returns", 32'(if_seen), 32'd4);
      chk("t4_ld_returns", 32'(ld_seen), 32'd4);

      // T5: load granted, then reset the next cycle; the load must vanish.
      bus.ld_req = 1; bus.ld_addr = 11'h033;
      do_cycle();
      idle();
      resetn = 1;
      do_cycle();
      resetn = 0;
      ld_seen = 0;
      for (int i = 0; i < 4; i++) begin
         do_cycle();
         ld_seen += int'(obs_ld_rvalid);
      end
      chk("t5_ld_dropped", 32'(ld_seen), 32'd0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         resetn = ($urandom_range(63) == 0);
         if (!(bus.if_req && !obs_if_gnt)) bus.if_addr = ADDR_W'($urandom_range(31));
         bus.if_req   = ($urandom_range(3) != 0);
         bus.ld_req   = $urandom_range(1) == 1;
         bus.st_req   = ($urandom_range(2) == 0);
         bus.ld_addr  = ADDR_W'($urandom_range(31));
         bus.st_addr  = ADDR_W'($urandom_range(31));
         bus.st_wdata = $urandom;
         do_cycle();
      end
      resetn = 0;
      idle();
      repeat (2 + RD_LAT) do_cycle();
      chk("drain_empty", 32'(pend.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
